seg_display_scheduler: RTL and testbench
========================================

// Module: seg_display_scheduler
// PURPOSE
//  Shares the single 4-digit seven-segment display among NUM_REQ requesters (score, timer, message...).
//  Round-robin grant with a minimum dwell time, live value update while owned, clamp to 9999,
//  leading-zero blanking and per-requester blink. Drives num3..num0/mask of the SevenSegment block.
// PARAMETERS
//  NUM_REQ     3           number of requesters (2..8)
//  DWELL_CYC   25_000_000  min cycles a grant is held once another requester is waiting (1 s @ 25 MHz)
//  BLINK_HALF  6_250_000   cycles per blink half-period (on phase, then off phase)
// PORTS
//  clk       in   1            25 MHz clock
//  rst       in   1            asynchronous reset, active-low
//  req       in   NUM_REQ      request to show a value; level-sensitive, held while wanted
//  value     in   16*NUM_REQ   binary value per requester, slice i = value[16*i+:16]
//  blink_en  in   NUM_REQ      owner's digits blink while its bit is set
//  grant     out  NUM_REQ      one-hot current owner, all-zero when idle
//  active    out  1            display shows an owner's value
//  num3..0   out  4 each       16-bit binary to display, num3 = bits[15:12] ... num0 = bits[3:0]
//  mask      out  4            digit enables, bit3 = leftmost
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, grant=0, active=0, num3..0=0, mask=0000, rr pointer=0, counters=0.
//  FSM IDLE -> SHOW -> HANDOFF -> SHOW/IDLE; all outputs registered.
//  - IDLE: outputs blank (mask=0000, num=0). Any req bit set -> pick first set bit scanning up from
//    rr pointer (wrap) -> SHOW next cycle with grant set; dwell and blink counters cleared.
//  - SHOW: each cycle num <= min(value[owner],9999) (1-cycle latency, live tracking); dwell counts up
//    while any other req bit is set, saturating at DWELL_CYC-1; dwell clears if none waiting.
//    Owner drops req -> HANDOFF immediately (dwell ignored).
//    Dwell reaches DWELL_CYC-1 with another req pending -> HANDOFF.
//  - HANDOFF: one cycle, grant=0, mask=0000 (blank gap, no glitch between owners); rr pointer <=
//    owner+1 mod NUM_REQ. Next: pending req -> SHOW with new owner chosen from rr pointer; else IDLE.
//    The just-released owner is lowest priority for the rearbitration (rr pointer past it); it
//    regains the display only if it is the sole requester.
//  Mask in SHOW (after clamp v):
//   leading-zero blank: v>=1000 -> 1111; v>=100 -> 0111; v>=10 -> 0011; else 0001 (0 shows "0").
//   blink: blink counter free-runs 0..2*BLINK_HALF-1 from grant start; first BLINK_HALF cycles on,
//   next BLINK_HALF cycles mask=0000 if blink_en[owner]. blink_en sampled each cycle (dropping it
//   mid-off-phase restores digits next cycle).
//  Clamp: value > 9999 displays 9999 (mask 1111).
//  Simultaneous: owner drop and new req same cycle -> HANDOFF then new owner. Multiple new reqs
//   from IDLE -> round-robin order from rr pointer. req pulses in HANDOFF count.
//  active = 1 only in SHOW. grant and num/mask change on the same edge.
//  Reset mid-SHOW: outputs blank asynchronously; on release restart in IDLE, rr pointer 0.
// STRUCTURE
//  Shared package: FSM state enum (IDLE/SHOW/HANDOFF), MAX_DISPLAY=9999, digit-threshold constants.
//  One sub-module: seg_rr_pick (combinational round-robin first-set-bit search from pointer, returns
//   one-hot + index + found). Counters, clamp and mask logic stay in the top.
// TESTING (bench params: NUM_REQ=3, DWELL_CYC=8, BLINK_HALF=2)
//  1 Reset: rst=0 mid-SHOW -> grant=000, mask=0000, num=0 without clock edge; after release IDLE.
//  2 Single req: req=001, value0=42 -> next cycle grant=001, active=1, {num}=0x002A, mask=0011;
//    value0 -> 12345 -> next cycle 0x270F, mask=1111; no handoff ever occurs.
//  3 Contention: req0 owned, req=011 from cycle t -> grant stays 001 for 8 cycles, one blank HANDOFF
//    cycle (grant=000), then grant=010; with req=111 held, order 001,010,100,001.
//  4 Owner drop: owner req0 falls at cycle 2 of dwell, req2 pending -> HANDOFF next cycle, then 100.
//  5 Blink: blink_en0=1, value0=7 -> mask 0001,0001,0000,0000 repeating from grant; blink_en0=0
//    during off phase -> mask 0001 next cycle.
//  6 Boundaries: value0=0 -> mask 0001; 9,10,99,100,999,1000 -> 0001,0011,0011,0111,0111,1111.

Source files
------------

// File: rtl/seg_display_scheduler_pkg.sv
// rtl/seg_display_scheduler_pkg.sv - shared types and constants for the seven-segment display scheduler
package seg_display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHOW    = 2'd1,
        ST_HANDOFF = 2'd2
    } state_e;

    localparam logic [15:0] MAX_DISPLAY = 16'd9999;
    localparam logic [15:0] THR_4DIG    = 16'd1000;
    localparam logic [15:0] THR_3DIG    = 16'd100;
    localparam logic [15:0] THR_2DIG    = 16'd10;

    function automatic logic [15:0] clamp_display(input logic [15:0] v);
        return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
    endfunction

    // Leading-zero blanking; the rightmost digit is always lit so zero shows "0".
    function automatic logic [3:0] digit_mask(input logic [15:0] v);
        if (v >= THR_4DIG) return 4'b1111;
        if (v >= THR_3DIG) return 4'b0111;
        if (v >= THR_2DIG) return 4'b0011;
        return 4'b0001;
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// rtl/seg_rr_pick.sv - combinational round-robin first-set-bit search starting at a pointer
module seg_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int            j;
    logic [IW-1:0] j_idx;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        j        = 0;
        j_idx    = '0;
        for (int k = 0; k < N; k++) begin
            j     = (int'(ptr_i) + k) % N;
            j_idx = IW'(j);
            if (!found_o && req_i[j_idx]) begin
                found_o         = 1'b1;
                idx_o           = j_idx;
                onehot_o[j_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - round-robin owner of the 4-digit display with dwell, clamp, blanking and blink
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DWELL_CYC  = 25_000_000,
    parameter int BLINK_HALF = 6_250_000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [16*NUM_REQ-1:0]  value_i,
    input  logic [NUM_REQ-1:0]     blink_en_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   active_o,
    output logic [3:0]             num3_o,
    output logic [3:0]             num2_o,
    output logic [3:0]             num1_o,
    output logic [3:0]             num0_o,
    output logic [3:0]             mask_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int BW = $clog2(2 * BLINK_HALF);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_OFF  = BW'(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
    localparam logic [IW-1:0] OWNER_LAST = IW'(NUM_REQ - 1);
    localparam logic [IW-1:0] OWNER_ONE  = IW'(1);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        rr_q;
    logic [DW-1:0]        dwell_q;
    logic [BW-1:0]        blink_q;
    logic [15:0]          num_q;
    logic [3:0]           mask_q;
    logic                 active_q;

    logic [15:0]          vals [NUM_REQ];
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_found;
    logic [15:0]          pick_val_d;
    logic [15:0]          owner_val_d;
    logic [BW-1:0]        blink_d;
    logic [IW-1:0]        rr_d;
    logic                 others_waiting;
    logic                 blink_off;
    logic                 release_owner;

    seg_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (rr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            vals[i] = value_i[16*i +: 16];
        end
    end

    always_comb begin
        pick_val_d     = clamp_display(vals[pick_idx]);
        owner_val_d    = clamp_display(vals[owner_q]);
        others_waiting = |(req_i & ~grant_q);
        blink_d        = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_ONE;
        blink_off      = (blink_d >= BLINK_OFF) && blink_en_i[owner_q];
        rr_d           = (owner_q == OWNER_LAST) ? '0 : owner_q + OWNER_ONE;
        // Owner dropping its request overrides any dwell still owed to it.
        release_owner  = !req_i[owner_q] || (others_waiting && (dwell_q == DWELL_LAST));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
            dwell_q  <= '0;
            blink_q  <= '0;
            num_q    <= '0;
            mask_q   <= '0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HANDOFF: begin
                    if (pick_found) begin
                        state_q  <= ST_SHOW;
                        grant_q  <= pick_onehot;
                        owner_q  <= pick_idx;
                        active_q <= 1'b1;
                        num_q    <= pick_val_d;
                        mask_q   <= digit_mask(pick_val_d);
                        dwell_q  <= '0;
                        blink_q  <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHOW: begin
                    if (release_owner) begin
                        // Blank gap cycle; pointer moves past the releasing owner.
                        state_q  <= ST_HANDOFF;
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        num_q    <= '0;
                        mask_q   <= '0;
                        dwell_q  <= '0;
                        rr_q     <= rr_d;
                    end else begin
                        num_q   <= owner_val_d;
                        mask_q  <= blink_off ? 4'b0000 : digit_mask(owner_val_d);
                        blink_q <= blink_d;
                        if (!others_waiting)
                            dwell_q <= '0;
                        else if (dwell_q != DWELL_LAST)
                            dwell_q <= dwell_q + DWELL_ONE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= '0;
                    active_q <= 1'b0;
                    num_q    <= '0;
                    mask_q   <= '0;
                end
            endcase
        end
    end

    assign grant_o  = grant_q;
    assign active_o = active_q;
    assign num3_o   = num_q[15:12];
    assign num2_o   = num_q[11:8];
    assign num1_o   = num_q[7:4];
    assign num0_o   = num_q[3:0];
    assign mask_o   = mask_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - directed scoreboard bench for seg_display_scheduler
module tb_seg_display_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  blink_en;
    logic [47:0] value;
    logic [2:0]  grant;
    logic        active;
    logic [3:0]  n3, n2, n1, n0, mask;
    logic [23:0] obs_v;

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .NUM_REQ    (3),
        .DWELL_CYC  (8),
        .BLINK_HALF (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .value_i    (value),
        .blink_en_i (blink_en),
        .grant_o    (grant),
        .active_o   (active),
        .num3_o     (n3),
        .num2_o     (n2),
        .num1_o     (n1),
        .num0_o     (n0),
        .mask_o     (mask)
    );

    assign obs_v = {grant, active, n3, n2, n1, n0, mask};

    typedef struct {
        string       tag;
        logic [23:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [23:0] BLANK = 24'h0;

    function automatic logic [23:0] ev(input logic [2:0] g, input logic a,
                                       input logic [15:0] n, input logic [3:0] m);
        return {g, a, n, m};
    endfunction

    task automatic expect_next(input string tag, input logic [23:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic compare_head();
        exp_t x;
        if (sb.size() == 0) return;
        x = sb.pop_front();
        total++;
        assert (obs_v === x.exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", x.tag, obs_v, x.exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [23:0] e);
        expect_next(tag, e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    logic [15:0] bv [9] = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000};
    logic [15:0] bn [9] = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd9999};
    logic [3:0]  bm [9] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0]  blink_pat [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = 3'b000;
        blink_en = 3'b000;
        value    = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_next("reset_state", BLANK);
        compare_head();
        rst_n = 1'b1;
        cyc("idle_no_req", BLANK);

        value[15:0] = 16'd42;
        req = 3'b001;
        cyc("single_42", ev(3'b001, 1'b1, 16'h002A, 4'b0011));
        value[15:0] = 16'd12345;
        cyc("clamp_12345", ev(3'b001, 1'b1, 16'h270F, 4'b1111));
        for (int i = 0; i < 12; i++)
            cyc("single_no_handoff", ev(3'b001, 1'b1, 16'h270F, 4'b1111));

        for (int i = 0; i < 9; i++) begin
            value[15:0] = bv[i];
            cyc($sformatf("boundary_%0d", bv[i]), ev(3'b001, 1'b1, bn[i], bm[i]));
        end

        value[15:0]  = 16'd7;
        value[31:16] = 16'd11;
        value[47:32] = 16'd222;
        cyc("own0_v7", ev(3'b001, 1'b1, 16'd7, 4'b0001));
        req = 3'b011;
        for (int i = 0; i < 7; i++)
            cyc("dwell_hold0", ev(3'b001, 1'b1, 16'd7, 4'b0001));
        cyc("handoff_gap0", BLANK);
        cyc("grant1", ev(3'b010, 1'b1, 16'd11, 4'b0011));
        req = 3'b111;
        for (int i = 0; i < 7; i++)
            cyc("rr_hold1", ev(3'b010, 1'b1, 16'd11, 4'b0011));
        cyc("handoff_gap1", BLANK);
        cyc("grant2", ev(3'b100, 1'b1, 16'd222, 4'b0111));
        for (int i = 0; i < 7; i++)
            cyc("rr_hold2", ev(3'b100, 1'b1, 16'd222, 4'b0111));
        cyc("handoff_gap2", BLANK);
        cyc("grant0_wrap", ev(3'b001, 1'b1, 16'd7, 4'b0001));

        req = 3'b101;
        cyc("drop_hold_a", ev(3'b001, 1'b1, 16'd7, 4'b0001));
        cyc("drop_hold_b", ev(3'b001, 1'b1, 16'd7, 4'b0001));
        req = 3'b100;
        cyc("drop_gap", BLANK);
        cyc("drop_grant2", ev(3'b100, 1'b1, 16'd222, 4'b0111));

        rst_n = 1'b0;
        req   = 3'b011;
        #2;
        expect_next("async_reset", BLANK);
        compare_head();
        cyc("reset_held", BLANK);
        req   = 3'b000;
        rst_n = 1'b1;
        cyc("post_reset_idle", BLANK);
        req = 3'b011;
        cyc("rr_reset_pick0", ev(3'b001, 1'b1, 16'd7, 4'b0001));

        req = 3'b000;
        cyc("release_gap", BLANK);
        cyc("back_to_idle", BLANK);
        req      = 3'b001;
        blink_en = 3'b001;
        for (int i = 0; i < 7; i++)
            cyc($sformatf("blink_%0d", i), ev(3'b001, 1'b1, 16'd7, blink_pat[i]));
        blink_en = 3'b000;
        cyc("blink_drop", ev(3'b001, 1'b1, 16'd7, 4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
